// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES encryption and decryption round controllers:
// round counts, datapath mode codes and the controller state encoding.
package aes_ctrl_pkg;

  localparam int NR128 = 10;
  localparam int NR256 = 14;

  localparam logic [1:0] MODE_ARK = 2'b11;
  localparam logic [1:0] MODE_RND = 2'b00;
  localparam logic [1:0] MODE_FIN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  // Round count for the latched key width, narrowed to the 4-bit counter domain.
  function automatic logic [3:0] nr_sel(input logic aes256, input int nr128, input int nr256);
    return aes256 ? 4'(nr256) : 4'(nr128);
  endfunction

endpackage

// File: rtl/fsm_dec_if.sv
// Control/status bundle between the AES decryption controller and its user
// (request side) plus the datapath strobes it drives.
interface fsm_dec_if;
  logic       stall;
  logic       start;
  logic       key_type;
  logic       key_reuse;
  logic       d_en;
  logic       k_en;
  logic       reset_out;
  logic [1:0] mode;
  logic       key_sel;
  logic       rk_we;
  logic [3:0] rk_addr;
  logic       ready;
  logic       done;

  modport master (
    output stall, start, key_type, key_reuse,
    input  d_en, k_en, reset_out, mode, key_sel, rk_we, rk_addr, ready, done
  );

  modport slave (
    input  stall, start, key_type, key_reuse,
    output d_en, k_en, reset_out, mode, key_sel, rk_we, rk_addr, ready, done
  );
endinterface

// File: rtl/round_counter.sv
// 4-bit up/down round counter with synchronous load, stall hold and
// terminal/one compares used by the AES round controllers.
module round_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] term,
  output logic [3:0] cnt,
  output logic       at_term,
  output logic       at_one
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!stall) begin
      if (load) begin
        cnt_d = load_val;
      end else if (inc) begin
        cnt_d = cnt_q + 4'd1;
      end else if (dec) begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);
  assign at_one  = (cnt_q == 4'd1);

endmodule

// File: rtl/fsm_dec.sv
// AES-128/256 decryption controller: expands the key schedule into the round-key
// buffer, then replays it last-to-first through the inverse-round datapath.
module fsm_dec
  import aes_ctrl_pkg::*;
#(
  parameter int NR128 = aes_ctrl_pkg::NR128,
  parameter int NR256 = aes_ctrl_pkg::NR256
) (
  input  logic      clk,
  input  logic      reset_in,
  fsm_dec_if.slave  bus
);

  state_e     state_q, state_d;
  logic       type_q, type_d;
  logic       key_valid_q, key_valid_d;
  logic       full_q, full_d;

  logic [3:0] nr;
  logic [3:0] cnt;
  logic       cnt_load;
  logic [3:0] cnt_val;
  logic       cnt_inc;
  logic       cnt_dec;
  logic       at_term;
  logic       at_one;

  assign nr = nr_sel(type_q, NR128, NR256);

  round_counter u_cnt (
    .clk      (clk),
    .rst      (reset_in),
    .stall    (bus.stall),
    .load     (cnt_load),
    .load_val (cnt_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .term     (nr),
    .cnt      (cnt),
    .at_term  (at_term),
    .at_one   (at_one)
  );

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    key_valid_d = key_valid_q;
    full_d      = full_q;
    cnt_load    = 1'b0;
    cnt_val     = 4'd0;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    if (!bus.stall) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_LOAD;
            // Reuse only when the stored schedule was built for the same key width.
            if (bus.key_reuse && key_valid_q && (bus.key_type == type_q)) begin
              full_d = 1'b0;
            end else begin
              full_d      = 1'b1;
              type_d      = bus.key_type;
              key_valid_d = 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (full_q) begin
            state_d  = ST_EXPAND;
            cnt_load = 1'b1;
            cnt_val  = 4'd1;
          end else begin
            state_d = ST_INIT;
          end
        end
        ST_EXPAND: begin
          if (at_term) begin
            state_d     = ST_INIT;
            key_valid_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_INIT: begin
          state_d  = ST_ROUND;
          cnt_load = 1'b1;
          cnt_val  = nr - 4'd1;
        end
        ST_ROUND: begin
          if (at_one) begin
            state_d = ST_FINAL;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_FINAL: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      type_q      <= 1'b0;
      key_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      key_valid_q <= key_valid_d;
      full_q      <= full_d;
    end
  end

  // Moore output decode from registered state and counter.
  always_comb begin
    bus.d_en      = 1'b0;
    bus.k_en      = 1'b0;
    bus.reset_out = 1'b0;
    bus.mode      = MODE_ARK;
    bus.key_sel   = type_q;
    bus.rk_we     = 1'b0;
    bus.rk_addr   = 4'd0;
    bus.ready     = 1'b0;
    bus.done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.ready     = 1'b1;
        bus.reset_out = 1'b1;
      end
      ST_LOAD: begin
        bus.d_en  = 1'b1;
        bus.k_en  = full_q;
        bus.rk_we = full_q;
      end
      ST_EXPAND: begin
        bus.rk_we   = 1'b1;
        bus.rk_addr = cnt;
      end
      ST_INIT: begin
        bus.mode    = MODE_ARK;
        bus.rk_addr = nr;
      end
      ST_ROUND: begin
        bus.mode    = MODE_RND;
        bus.rk_addr = cnt;
      end
      ST_FINAL: begin
        bus.mode    = MODE_FIN;
        bus.rk_addr = 4'd0;
      end
      ST_DONE: bus.done = 1'b1;
      default: bus.ready = 1'b0;
    endcase
  end

endmodule
